// File: rtl/flash_resp_pkg.sv
// Shared types and constants for the flash memory responder: FSM states,
// burst-count width, default parameters and the built-in ROM pattern.
package flash_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STALL  = 3'd1,
        S_ACCEPT = 3'd2,
        S_BURST  = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam int BURST_W          = 6;
    localparam int DEF_ADDR_W       = 23;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_DEPTH        = 1024;
    localparam int DEF_WAIT_CYCLES  = 2;
    localparam int DEF_READ_LATENCY = 2;

    localparam logic [31:0] PATTERN_BASE = 32'hA500_0000;

    function automatic logic [31:0] pattern_word(input logic [31:0] idx);
        return PATTERN_BASE | idx;
    endfunction

endpackage

// File: rtl/flash_word_rom.sv
// Synchronous-read ROM returning the built-in pattern word for each index.
// The output register is the first stage of the responder's read pipeline.
module flash_word_rom
    import flash_resp_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [IDX_W-1:0]  i_index,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_q;

    assign w_word = DATA_W'(pattern_word(32'(i_index)));

    // Output register only updates on a fetch so it holds the last word read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_word;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/flash_mem_responder.sv
// Avalon-MM read slave standing in for the flash device: stalls each command,
// accepts it for one cycle, then streams a burst after a fixed read latency.
module flash_mem_responder
    import flash_resp_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flash_mem_read,
    input  logic               flash_mem_write,
    input  logic [ADDR_W-1:0]  flash_mem_address,
    input  logic [BURST_W-1:0] flash_mem_burstcount,
    output logic               flash_mem_waitrequest,
    output logic [DATA_W-1:0]  flash_mem_readdata,
    output logic               flash_mem_readdatavalid,
    output logic               write_seen,
    output logic               busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int DP_N  = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [READ_LATENCY-1:0] LAST_MASK = READ_LATENCY'(1) << (READ_LATENCY - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [3:0]          w_next_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [BURST_W-1:0]  r_remain;
    logic [BURST_W-1:0]  w_next_remain;
    logic                w_fetch;
    logic                w_set_write;
    logic                w_cmd;
    logic                w_pipe_last;
    logic [READ_LATENCY-1:0] r_vpipe;
    logic [DATA_W-1:0]   r_dpipe [DP_N];
    logic [DATA_W-1:0]   w_rom_q;
    logic                r_waitreq;
    logic                r_busy;
    logic                r_write_seen;

    assign w_cmd       = flash_mem_read | flash_mem_write;
    // True when at most the final stage still holds a word, i.e. the pipe empties at this edge.
    assign w_pipe_last = ((r_vpipe & ~LAST_MASK) == '0);

    // Next-state, counter and fetch decisions.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_addr   = r_addr;
        w_next_remain = r_remain;
        w_fetch       = 1'b0;
        w_set_write   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd) begin
                    w_next_cnt   = 4'(WAIT_CYCLES);
                    w_next_state = (WAIT_CYCLES == 0) ? S_ACCEPT : S_STALL;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_STALL: begin
                if (!w_cmd) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next_state = S_ACCEPT;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_ACCEPT: begin
                if (flash_mem_read) begin
                    w_next_state  = S_BURST;
                    w_next_addr   = flash_mem_address;
                    w_next_remain = (flash_mem_burstcount == '0) ? BURST_W'(1) : flash_mem_burstcount;
                end else if (flash_mem_write) begin
                    w_next_state = S_IDLE;
                    w_set_write  = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BURST: begin
                w_fetch       = 1'b1;
                w_next_addr   = r_addr + ADDR_W'(1);
                w_next_remain = r_remain - BURST_W'(1);
                if (r_remain == BURST_W'(1)) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_BURST;
                end
            end
            S_DRAIN: begin
                if (w_pipe_last) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_remain     <= '0;
            r_waitreq    <= 1'b1;
            r_busy       <= 1'b0;
            r_write_seen <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_addr       <= w_next_addr;
            r_remain     <= w_next_remain;
            r_waitreq    <= (w_next_state != S_ACCEPT);
            r_busy       <= (w_next_state != S_IDLE);
            r_write_seen <= r_write_seen | w_set_write;
        end
    end

    flash_word_rom #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_rom (
        .clk     (clk),
        .rst_n   (rst),
        .i_en    (w_fetch),
        .i_index (r_addr[IDX_W-1:0]),
        .o_q     (w_rom_q)
    );

    // Valid tag pipe; bit 0 travels alongside the ROM register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_fetch;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // Data stages after the ROM; each holds until a valid word moves into it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DP_N; i++) begin
                r_dpipe[i] <= '0;
            end
        end else begin
            if (r_vpipe[0]) begin
                r_dpipe[0] <= w_rom_q;
            end
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                if (r_vpipe[i]) begin
                    r_dpipe[i] <= r_dpipe[i-1];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_out_rom
            assign flash_mem_readdata = w_rom_q;
        end else begin : g_out_pipe
            assign flash_mem_readdata = r_dpipe[READ_LATENCY-2];
        end
    endgenerate

    assign flash_mem_readdatavalid = r_vpipe[READ_LATENCY-1];
    assign flash_mem_waitrequest   = r_waitreq;
    assign busy                    = r_busy;
    assign write_seen              = r_write_seen;

endmodule

// File: tb/tb_flash_mem_responder.sv
// Self-checking bench for flash_mem_responder: a cycle-stamped bus monitor is
// compared against expected accept/data timing and pattern words from plain arithmetic.
module tb_flash_mem_responder;

    localparam int W  = 2;
    localparam int L  = 2;
    localparam int AW = 23;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd  = 1'b0;
    logic          wr  = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [5:0]    bc   = 6'd0;
    logic          waitreq;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wseen;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int            acc_q[$];
    int            vcyc_q[$];
    logic [DW-1:0] vdat_q[$];

    flash_mem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(1024), .WAIT_CYCLES(W), .READ_LATENCY(L)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .flash_mem_read          (rd),
        .flash_mem_write         (wr),
        .flash_mem_address       (addr),
        .flash_mem_burstcount    (bc),
        .flash_mem_waitrequest   (waitreq),
        .flash_mem_readdata      (rdata),
        .flash_mem_readdatavalid (rvalid),
        .write_seen              (wseen),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid) begin
            vcyc_q.push_back(cyc);
            vdat_q.push_back(rdata);
        end
        if (!waitreq) acc_q.push_back(cyc);
    end

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a, input int k);
        logic [AW-1:0] x;
        x = a + AW'(k);
        return 32'hA500_0000 | 32'(x % 23'd1024);
    endfunction

    task automatic clear_mon();
        acc_q.delete();
        vcyc_q.delete();
        vdat_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_timeout busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({waitreq, rvalid, rdata, wseen, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold got wr=%b v=%b d=%h ws=%b b=%b want 1 0 0 0 0",
                     waitreq, rvalid, rdata, wseen, busy);
        end
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({waitreq, rvalid, busy} !== {1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release got wr=%b v=%b b=%b want 1 0 0", waitreq, rvalid, busy);
        end
    endtask

    task automatic test_read(input logic [AW-1:0] a, input logic [5:0] b, input string name);
        int s, t, n;
        clear_mon();
        @(posedge clk);
        #1;
        rd = 1'b1; addr = a; bc = b;
        s = cyc + 1;
        t = 0;
        while (acc_q.size() == 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1 rd = 1'b0;
        addr = 23'(($urandom));
        wait_idle(name);
        n = (b == 6'd0) ? 1 : int'(b);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] != s + W) begin
            failures++;
            $display("FAIL %s accept n=%0d first_cyc=%0d want 1 at %0d", name, acc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : -1, s + W);
        end
        checks++;
        if (vcyc_q.size() != n) begin
            failures++;
            $display("FAIL %s word_count got %0d want %0d", name, vcyc_q.size(), n);
        end
        for (int k = 0; k < n && k < vcyc_q.size(); k++) begin
            checks++;
            if (vcyc_q[k] != s + W + 1 + L + k || vdat_q[k] !== exp_word(a, k)) begin
                failures++;
                $display("FAIL %s word%0d got cyc=%0d data=%h want cyc=%0d data=%h", name, k,
                         vcyc_q[k], vdat_q[k], s + W + 1 + L + k, exp_word(a, k));
            end
        end
        checks++;
        if (rdata !== exp_word(a, n - 1)) begin
            failures++;
            $display("FAIL %s hold_data got %h want %h", name, rdata, exp_word(a, n - 1));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_read(23'($urandom), 6'($urandom_range(0, 12)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a1, a2;
        int n1, n2, t, f1, f2;
        a1 = 23'd1020; n1 = 5;
        a2 = 23'($urandom); n2 = 3;
        clear_mon();
        @(posedge clk);
        #1 rd = 1'b1; addr = a1; bc = 6'(n1);
        t = 0;
        while (acc_q.size() == 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1 addr = a2; bc = 6'(n2);
        t = 0;
        while (acc_q.size() < 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1 rd = 1'b0;
        wait_idle("b2b");
        checks++;
        if (acc_q.size() != 2 || vcyc_q.size() != n1 + n2) begin
            failures++;
            $display("FAIL b2b counts accepts=%0d words=%0d want 2 and %0d", acc_q.size(),
                     vcyc_q.size(), n1 + n2);
        end else begin
            checks++;
            if (acc_q[1] <= vcyc_q[n1-1]) begin
                failures++;
                $display("FAIL b2b overlap second_accept=%0d last_word1=%0d want greater",
                         acc_q[1], vcyc_q[n1-1]);
            end
            f1 = 0; f2 = 0;
            for (int k = 0; k < n1; k++) begin
                if (vcyc_q[k] != acc_q[0] + 1 + L + k || vdat_q[k] !== exp_word(a1, k)) f1++;
            end
            for (int k = 0; k < n2; k++) begin
                if (vcyc_q[n1+k] != acc_q[1] + 1 + L + k || vdat_q[n1+k] !== exp_word(a2, k)) f2++;
            end
            checks++;
            if (f1 != 0 || f2 != 0) begin
                failures++;
                $display("FAIL b2b words bad_first=%0d bad_second=%0d want 0 0", f1, f2);
            end
        end
    endtask

    task automatic test_read_drop();
        clear_mon();
        @(posedge clk);
        #1 rd = 1'b1; addr = 23'd77; bc = 6'd3;
        @(posedge clk);
        #1 rd = 1'b0;
        wait_idle("read_drop");
        checks++;
        if (acc_q.size() != 0 || vcyc_q.size() != 0) begin
            failures++;
            $display("FAIL read_drop got accepts=%0d words=%0d want 0 0", acc_q.size(), vcyc_q.size());
        end
    endtask

    task automatic test_write();
        int s, t;
        clear_mon();
        checks++;
        if (wseen !== 1'b0) begin
            failures++;
            $display("FAIL write_seen_pre got %b want 0", wseen);
        end
        @(posedge clk);
        #1 wr = 1'b1; addr = 23'd5; bc = 6'd2;
        s = cyc + 1;
        t = 0;
        while (acc_q.size() == 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1 wr = 1'b0;
        wait_idle("write");
        checks++;
        if (acc_q.size() != 1 || acc_q[0] != s + W || vcyc_q.size() != 0 || wseen !== 1'b1) begin
            failures++;
            $display("FAIL write got accepts=%0d cyc=%0d words=%0d ws=%b want 1 %0d 0 1",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : -1, s + W, vcyc_q.size(), wseen);
        end
        test_read(23'd9, 6'd1, "after_write");
        checks++;
        if (wseen !== 1'b1) begin
            failures++;
            $display("FAIL write_sticky got %b want 1", wseen);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_mon();
        @(posedge clk);
        #1 rd = 1'b1; addr = 23'd300; bc = 6'd20;
        t = 0;
        while (vcyc_q.size() < 3 && t < 60) begin
            @(negedge clk);
            t++;
        end
        rd = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({waitreq, rvalid, rdata, wseen, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got wr=%b v=%b d=%h ws=%b b=%b want 1 0 0 0 0",
                     waitreq, rvalid, rdata, wseen, busy);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        clear_mon();
        repeat (30) @(negedge clk);
        checks++;
        if (vcyc_q.size() != 0 || acc_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_stray got words=%0d accepts=%0d busy=%b want 0 0 0",
                     vcyc_q.size(), acc_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_read(23'd1001, 6'd1, "single");
        test_read(23'd1022, 6'd4, "rom_wrap");
        test_read(23'd5, 6'd0, "bc_zero");
        test_read(23'h7FFFFF, 6'd2, "addr_wrap");
        test_random();
        test_back_to_back();
        test_read_drop();
        test_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
